// File: rtl/rooms_pkg.sv
// Shared game types: room/game state enums, default move budget, saturating counter helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package rooms;

  typedef enum logic [3:0] {
    R1 = 4'd1, R2 = 4'd2, R3 = 4'd3, R4 = 4'd4, R5 = 4'd5,
    R6 = 4'd6, R7 = 4'd7, R8 = 4'd8, R9 = 4'd9
  } room_states;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    DEAD = 2'd3
  } game_states;

  localparam int MAX_MOVES_DEFAULT = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adventure_game_ctrl_btn_edge_detect.sv
// Turns a lone rising direction button into a one-cycle move strobe; strobe registered 1 cycle after the edge.
// No backpressure: en low suppresses the strobe, the press is dropped rather than held.
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_w,
  input  logic btn_e,
  output logic move_n,
  output logic move_s,
  output logic move_w,
  output logic move_e,
  output logic accept
);

  logic [3:0] btn;
  logic [3:0] prev;
  logic [3:0] rise;
  logic [3:0] pick;
  logic [3:0] mv;

  assign btn  = {btn_n, btn_s, btn_w, btn_e};
  assign rise = btn & ~prev;
  // Accept only when the rising button is the only one high, so chords never move.
  assign pick   = ($onehot(btn) && (rise == btn)) ? rise : 4'b0000;
  assign accept = en && (pick != 4'b0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 4'b0000;
      mv   <= 4'b0000;
    end else begin
      prev <= btn;
      mv   <= en ? pick : 4'b0000;
    end
  end

  assign {move_n, move_s, move_w, move_e} = mv;

endmodule

// File: rtl/adventure_game_ctrl.sv
// Game controller: start/win/death FSM, move strobes, item flags; optional move budget under MOVE_LIMIT_EN.
// Strobes and counters update 1 cycle after the sampled input; no backpressure, presses outside PLAY are dropped.
module adventure_game_ctrl
  import rooms::*;
#(
  parameter int MAX_MOVES = MAX_MOVES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_w,
  input  logic       btn_e,
  input  room_states room,
  output logic       move_n,
  output logic       move_s,
  output logic       move_w,
  output logic       move_e,
  output logic       room_rst,
  output logic       sword,
  output logic       treasure,
  output game_states game_state,
  output logic [7:0] move_count
);

  if (MAX_MOVES < 1 || MAX_MOVES > 255) begin : g_bad_max_moves
    $error("MAX_MOVES must be within 1..255");
  end

  game_states next_state;
  logic       limit_hit;
  logic       accept;
  logic       move_en;

`ifdef MOVE_LIMIT_EN
  assign limit_hit = (move_count == 8'(MAX_MOVES));
`else
  assign limit_hit = 1'b0;
`endif

  // R6 is checked first so a win on the last budgeted move beats the timeout.
  always_comb begin
    next_state = game_state;
    case (game_state)
      IDLE: if (start) next_state = PLAY;
      PLAY: begin
        if (room == R6)      next_state = WIN;
        else if (room == R7) next_state = DEAD;
        else if (limit_hit)  next_state = DEAD;
      end
      WIN, DEAD: if (start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes only land in cycles that are still PLAY, never on the exit edge.
  assign move_en  = (game_state == PLAY) && (next_state == PLAY);
  assign room_rst = (game_state == IDLE);

  btn_edge_detect u_btn (
    .clk    (clk),
    .reset  (reset),
    .en     (move_en),
    .btn_n  (btn_n),
    .btn_s  (btn_s),
    .btn_w  (btn_w),
    .btn_e  (btn_e),
    .move_n (move_n),
    .move_s (move_s),
    .move_w (move_w),
    .move_e (move_e),
    .accept (accept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      game_state <= IDLE;
      move_count <= 8'd0;
      sword      <= 1'b0;
      treasure   <= 1'b0;
    end else begin
      game_state <= next_state;
      if (game_state == IDLE && next_state == PLAY) begin
        move_count <= 8'd0;
        sword      <= 1'b0;
        treasure   <= 1'b0;
      end else if (game_state == PLAY) begin
        if (accept)     move_count <= sat_inc8(move_count);
        if (room == R4) sword      <= 1'b1;
        if (room == R8) treasure   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adventure_game_ctrl.sv
// Directed bench for adventure_game_ctrl; expected strobes queued at drive time, popped after the edge.
// Define MOVE_LIMIT_EN to exercise the move budget with MAX_MOVES=3.
module tb_adventure_game_ctrl;
  import rooms::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       btn_n, btn_s, btn_w, btn_e;
  room_states room;
  logic       move_n, move_s, move_w, move_e;
  logic       room_rst, sword, treasure;
  game_states game_state;
  logic [7:0] move_count;

  int         tests = 0;
  int         fails = 0;
  int         exp_cnt = 0;
  logic [3:0] exp_q[$];

  localparam logic [3:0] N = 4'b1000;
  localparam logic [3:0] S = 4'b0100;
  localparam logic [3:0] W = 4'b0010;
  localparam logic [3:0] E = 4'b0001;
  localparam logic [3:0] Z = 4'b0000;

  always #5 clk = ~clk;

`ifdef MOVE_LIMIT_EN
  adventure_game_ctrl #(.MAX_MOVES(3)) dut (
`else
  adventure_game_ctrl dut (
`endif
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .btn_n      (btn_n),
    .btn_s      (btn_s),
    .btn_w      (btn_w),
    .btn_e      (btn_e),
    .room       (room),
    .move_n     (move_n),
    .move_s     (move_s),
    .move_w     (move_w),
    .move_e     (move_e),
    .room_rst   (room_rst),
    .sword      (sword),
    .treasure   (treasure),
    .game_state (game_state),
    .move_count (move_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive buttons, queue the strobe expected after the edge, then compare.
  task automatic cyc(input logic [3:0] b, input logic [3:0] exp_mv);
    logic [3:0] want;
    {btn_n, btn_s, btn_w, btn_e} = b;
    exp_q.push_back(exp_mv);
    if (exp_mv != Z && exp_cnt < 255) exp_cnt++;
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    chk("strobe", {28'd0, move_n, move_s, move_w, move_e}, {28'd0, want});
    chk("move_count", {24'd0, move_count}, exp_cnt);
  endtask

  task automatic press(input logic [3:0] b);
    cyc(b, b);
    cyc(Z, Z);
  endtask

  task automatic go();
    exp_cnt = 0;
    start = 1'b1;
    cyc(Z, Z);
    start = 1'b0;
    chk("state_play", 32'(game_state), 32'(PLAY));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    {btn_n, btn_s, btn_w, btn_e} = Z;
    room = R1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_state", 32'(game_state), 32'(IDLE));
    chk("rst_room_rst", 32'(room_rst), 32'd1);
    chk("rst_strobes", {28'd0, move_n, move_s, move_w, move_e}, 32'd0);
    chk("rst_sword", 32'(sword), 32'd0);
    chk("rst_treasure", 32'(treasure), 32'd0);
    chk("rst_count", {24'd0, move_count}, 32'd0);
    reset = 1'b0;
    cyc(E, Z);
    cyc(Z, Z);
    chk("idle_hold", 32'(game_state), 32'(IDLE));

    // Game A: single press, chord, items, death, freeze
    go();
    chk("play_room_rst", 32'(room_rst), 32'd0);
    cyc(E, E);
    repeat (4) cyc(E, Z);
    cyc(Z, Z);
    cyc(N | W, Z);
    cyc(N | W, Z);
    cyc(Z, Z);
    room = R4; cyc(Z, Z);
    chk("sword_set", 32'(sword), 32'd1);
    chk("treasure_clear", 32'(treasure), 32'd0);
    room = R3; cyc(Z, Z);
    chk("sword_sticky", 32'(sword), 32'd1);
    room = R8; cyc(Z, Z);
    chk("treasure_set", 32'(treasure), 32'd1);
    room = R7; cyc(Z, Z);
    chk("state_dead", 32'(game_state), 32'(DEAD));
    chk("dead_sword", 32'(sword), 32'd1);
    room = R4; cyc(E, Z);
    room = R1; cyc(Z, Z);
    chk("dead_hold", 32'(game_state), 32'(DEAD));
    start = 1'b1; cyc(Z, Z); start = 1'b0;
    chk("dead_to_idle", 32'(game_state), 32'(IDLE));
    chk("idle_room_rst", 32'(room_rst), 32'd1);
    chk("idle_sword_kept", 32'(sword), 32'd1);
    go();
    chk("new_game_sword", 32'(sword), 32'd0);
    chk("new_game_treasure", 32'(treasure), 32'd0);

    // Game B: held button blocks a second rise, then reset mid-game
    cyc(W, W);
    cyc(W | N, Z);
    cyc(W, Z);
    cyc(Z, Z);
    press(S);
    chk("pre_reset_count", {24'd0, move_count}, 32'd2);
    reset = 1'b1;
    exp_cnt = 0;
    cyc(E, Z);
    chk("midrst_state", 32'(game_state), 32'(IDLE));
    chk("midrst_room_rst", 32'(room_rst), 32'd1);
    chk("midrst_sword", 32'(sword), 32'd0);
    reset = 1'b0;
    cyc(E, Z);
    cyc(Z, Z);

    // Game C: win on R6, which must also beat a coinciding budget timeout
    go();
    cyc(E, E); cyc(Z, Z);
    cyc(W, W); cyc(Z, Z);
    cyc(E, E);
    room = R6; cyc(Z, Z);
    chk("state_win", 32'(game_state), 32'(WIN));
    room = R1; cyc(N, Z);
    chk("win_hold", 32'(game_state), 32'(WIN));
    start = 1'b1; cyc(Z, Z); start = 1'b0;
    chk("win_to_idle", 32'(game_state), 32'(IDLE));

`ifdef MOVE_LIMIT_EN
    // Game D: budget of 3 moves
    go();
    cyc(E, E); cyc(Z, Z);
    cyc(W, W); cyc(Z, Z);
    cyc(E, E);
    chk("limit_still_play", 32'(game_state), 32'(PLAY));
    cyc(N, Z);
    chk("limit_dead", 32'(game_state), 32'(DEAD));
    cyc(Z, Z);
    cyc(N, Z);
    chk("limit_dead_hold", 32'(game_state), 32'(DEAD));
`else
    // Game D: move counter saturation
    go();
    repeat (260) press(E);
    chk("sat_count", {24'd0, move_count}, 32'd255);
    chk("sat_play", 32'(game_state), 32'(PLAY));
    room = R6; cyc(Z, Z);
    chk("sat_win", 32'(game_state), 32'(WIN));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
